// File: rtl/serial_mul5_tx.sv
// serial_mul5_tx: accepts a W-bit word k and shifts 5*k out MSB-first, OUT_W = W+3 bits per frame.
// Latency: 2 cycles from accept to the first bit. Each frame takes OUT_W+1 cycles, one of them the frame_clr pulse.
// Backpressure: in_ready is high only in IDLE. in_valid is ignored while busy. Optional MUL5_ERRINJ_EN adds err_inj.
module serial_mul5_tx #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
`ifdef MUL5_ERRINJ_EN
  input  logic         err_inj,
`endif
  output logic         in_ready,
  output logic         frame_clr,
  output logic         out_bit,
  output logic         out_valid,
  output logic         out_first,
  output logic         out_last,
  output logic         busy
);

  localparam int OUT_W = W + 3;
  localparam int CW    = $clog2(OUT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OUT_W-1:0]   r_sreg;
  logic [CW-1:0]      r_cnt;
  logic               w_accept;
  logic [OUT_W-1:0]   w_mul5;
  logic               w_flip;

  // 5*k as 4k + k. The result always fits in OUT_W bits.
  assign w_mul5 = {1'b0, in_data, 2'b00} + {3'b000, in_data};

`ifdef MUL5_ERRINJ_EN
  assign w_flip = err_inj;
`else
  assign w_flip = 1'b0;
`endif

  assign w_accept = in_valid && in_ready;

  // State register. Reset aborts any frame in progress at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and output decode. Outputs depend only on registered state.
  // The exception is in_ready, which is also gated by reset.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    frame_clr   = 1'b0;
    out_valid   = 1'b0;
    out_bit     = 1'b0;
    out_first   = 1'b0;
    out_last    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = reset;
        if (w_accept) begin
          w_state_nxt = CLR;
        end
      end
      CLR: begin
        frame_clr   = 1'b1;
        busy        = 1'b1;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_bit   = r_sreg[OUT_W-1];
        out_first = (r_cnt == CW'(OUT_W - 1));
        out_last  = (r_cnt == '0);
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath. Load the product on accept, then shift it out and count down while in SHIFT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_sreg <= w_mul5 ^ {{(OUT_W-1){1'b0}}, w_flip};
        r_cnt  <= CW'(OUT_W - 1);
      end
    end else if (r_state == SHIFT) begin
      r_sreg <= r_sreg << 1;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_mul5_tx.sv
// Testbench for serial_mul5_tx: sends frames from a table of directed vectors, then a few hand-written sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
// A serial mod-5 model stands in for the downstream divisibility checker.
module tb_serial_mul5_tx;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
`ifdef MUL5_ERRINJ_EN
  logic       err_inj;
`endif
  logic       in_ready, frame_clr, out_bit, out_valid, out_first, out_last, busy;

  int n_checks;
  int n_fails;

  serial_mul5_tx #(.W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef MUL5_ERRINJ_EN
    .err_inj   (err_inj),
`endif
    .in_ready  (in_ready),
    .frame_clr (frame_clr),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] k;
    logic       err;
    int         exp_val;
  } vec_t;

  // Call this on a falling edge while the DUT is idle. It sends one word and checks the whole frame.
  task automatic send_frame(input logic [7:0] k, input logic e, input int exp_val);
    int   val;
    int   rem;
    logic bad;
    chk($sformatf("rdy_before k=%0d", k), int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = k;
`ifdef MUL5_ERRINJ_EN
    err_inj  = e;
`endif
    @(negedge clk);
    chk($sformatf("clr_pulse k=%0d", k), int'(frame_clr), 1);
    chk($sformatf("clr_no_valid k=%0d", k), int'(out_valid), 0);
    chk($sformatf("clr_rdy_low k=%0d", k), int'(in_ready), 0);
    in_valid = 1'b0;
    in_data  = 8'hA5;
`ifdef MUL5_ERRINJ_EN
    err_inj  = 1'b0;
`endif
    val = 0;
    rem = 0;
    bad = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (!out_valid || frame_clr || in_ready || !busy ||
          (out_first != (i == 0)) || (out_last != (i == 10)))
        bad = 1'b1;
      val = val * 2 + int'(out_bit);
      rem = (rem * 2 + int'(out_bit)) % 5;
    end
    chk($sformatf("frame_flags k=%0d", k), int'(bad), 0);
    chk($sformatf("frame_value k=%0d", k), val, exp_val);
    chk($sformatf("checker_out k=%0d", k), int'(rem == 0), int'(e == 1'b0));
    @(negedge clk);
    chk($sformatf("rdy_after k=%0d", k), int'(in_ready), 1);
    chk($sformatf("idle_after k=%0d", k), int'(busy | out_valid | frame_clr), 0);
  endtask

  vec_t vecs[$];

  initial begin
    int   rdy_low;
    int   val1, val2;
    int   clr_cnt;
    logic [11:0] outs;

    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
`ifdef MUL5_ERRINJ_EN
    err_inj  = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    outs = {in_ready, frame_clr, out_bit, out_valid, out_first, out_last, busy, 5'b0};
    chk("reset_outputs", int'(outs), 0);
    reset = 1'b1;
    #1;
    chk("rdy_after_release", int'(in_ready), 1);
    chk("busy_after_release", int'(busy), 0);
    @(negedge clk);

    // Table of directed vectors
    vecs.push_back('{k: 8'd0,   err: 1'b0, exp_val: 0});
    vecs.push_back('{k: 8'd1,   err: 1'b0, exp_val: 5});
    vecs.push_back('{k: 8'd255, err: 1'b0, exp_val: 1275});
    vecs.push_back('{k: 8'd51,  err: 1'b0, exp_val: 255});
    vecs.push_back('{k: 8'd128, err: 1'b0, exp_val: 640});
`ifdef MUL5_ERRINJ_EN
    vecs.push_back('{k: 8'd4,   err: 1'b1, exp_val: 21});
    vecs.push_back('{k: 8'd4,   err: 1'b0, exp_val: 20});
    vecs.push_back('{k: 8'd255, err: 1'b1, exp_val: 1274});
`endif
    foreach (vecs[i]) send_frame(vecs[i].k, vecs[i].err, vecs[i].exp_val);

    // Back-to-back: in_valid stays high. The data changes while busy and must not be sampled.
    in_valid = 1'b1;
    in_data  = 8'd3;
    rdy_low  = 0;
    val1     = 0;
    val2     = 0;
    clr_cnt  = 0;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (frame_clr) clr_cnt++;
      if (c == 1) begin
        chk("b2b_clr1", int'(frame_clr), 1);
        in_data = 8'd7;
      end
      if (c == 14) begin
        chk("b2b_clr2", int'(frame_clr), 1);
        in_valid = 1'b0;
      end
      if (c <= 12 && !in_ready) rdy_low++;
      if (c == 13) chk("b2b_rdy_gap", int'(in_ready), 1);
      if (c >= 2 && c <= 12) val1 = val1 * 2 + int'(out_bit);
      if (c >= 15 && c <= 25) val2 = val2 * 2 + int'(out_bit);
      if (out_valid && frame_clr) chk("b2b_clr_valid_overlap", 1, 0);
    end
    chk("b2b_rdy_low_cycles", rdy_low, 12);
    chk("b2b_frame1", val1, 15);
    chk("b2b_frame2", val2, 35);
    chk("b2b_clr_count", clr_cnt, 2);
    chk("b2b_idle_end", int'(busy), 0);

    // Reset in the middle of the frame for k=200
    in_valid = 1'b1;
    in_data  = 8'd200;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_bit5_valid", int'(out_valid), 1);
    #1;
    reset = 1'b0;
    #1;
    outs = {in_ready, frame_clr, out_bit, out_valid, out_first, out_last, busy, 5'b0};
    chk("midrst_outputs", int'(outs), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_idle", int'(busy), 0);
    send_frame(8'd2, 1'b0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
